// File: rtl/truth_table_sweeper_if.sv
// Purpose : bundles the sweeper's control, stimulus and result signals.
// Latency : none (wiring only).
// Backpressure : none; start is a one-cycle request and is ignored while a sweep runs.
//
// Signals (N = swept input width):
//   start            : one-cycle request to begin a sweep
//   vec[N-1:0]       : vector driven to both implementations under test
//   y_a, y_b         : outputs of implementation A and implementation B
//   busy             : high while a sweep is in progress
//   done             : one-cycle pulse when a sweep completes
//   pass             : last completed sweep had zero mismatches
//   mismatch_count   : mismatching vectors in the last or current sweep (N+1 bits)
//   first_fail_vec   : first vector, in sweep order, with y_a != y_b
//   first_fail_valid : first_fail_vec holds a captured value
//
// master = the sweeper; slave = the environment that drives start and the two
// implementations.
interface truth_table_sweeper_if #(
    parameter int N = 3
);
    logic         start;
    logic [N-1:0] vec;
    logic         y_a;
    logic         y_b;
    logic         busy;
    logic         done;
    logic         pass;
    logic [N:0]   mismatch_count;
    logic [N-1:0] first_fail_vec;
    logic         first_fail_valid;

    modport master (
        input  start, y_a, y_b,
        output vec, busy, done, pass, mismatch_count, first_fail_vec, first_fail_valid
    );

    modport slave (
        output start, y_a, y_b,
        input  vec, busy, done, pass, mismatch_count, first_fail_vec, first_fail_valid
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Purpose : exhaustively sweeps N inputs and compares two implementations bit-for-bit.
// Latency : busy for 2^N*HOLD cycles after start is accepted, then a one-cycle done.
// Backpressure : none; start is accepted only in IDLE and ignored otherwise.
//
// Ports:
//   clk  : single clock, all state changes on the rising edge
//   rst  : synchronous active-high reset, takes priority over start
//   bus  : truth_table_sweeper_if master modport (start, vec, y_a, y_b, status, results)
//
// Parameters:
//   N    : number of swept inputs (1..16)
//   HOLD : cycles each vector is held; y_a/y_b are sampled on the last of them (>=1)
//   GRAY : 0 = binary order, 1 = reflected-Gray order
module truth_table_sweeper #(
    parameter int N    = 3,
    parameter int HOLD = 1,
    parameter int GRAY = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    truth_table_sweeper_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Hold counter only needs to reach HOLD-1; keep at least one bit so the
    // HOLD=1 case still elaborates cleanly (it compares every cycle).
    localparam int              HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
    localparam logic [N-1:0]    IDX_LAST  = '1;

    state_t         state_q, state_d;
    logic [N-1:0]   idx_q, idx_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [N:0]     cnt_q, cnt_d;
    logic [N-1:0]   ffv_q, ffv_d;
    logic           ffvld_q, ffvld_d;
    logic           pass_q, pass_d;

    logic [N-1:0]   sweep_vec;
    logic           compare_edge;
    logic           miscompare;

    // Index is N bits wide; termination is detected explicitly on the compare
    // edge of the all-ones index, so the wrap back to 0 never re-enters SWEEP.
    assign sweep_vec    = (GRAY != 0) ? (idx_q ^ (idx_q >> 1)) : idx_q;
    assign compare_edge = (state_q == ST_SWEEP) && (hold_q == HOLD_LAST);
    assign miscompare   = compare_edge && (bus.y_a != bus.y_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
            ffv_q   <= '0;
            ffvld_q <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            ffv_q   <= ffv_d;
            ffvld_q <= ffvld_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        hold_d   = hold_q;
        cnt_d    = cnt_q;
        ffv_d    = ffv_q;
        ffvld_d  = ffvld_q;
        pass_d   = pass_q;
        bus.vec  = '0;
        bus.busy = 1'b0;
        bus.done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_SWEEP;
                    idx_d   = '0;
                    hold_d  = '0;
                    cnt_d   = '0;
                    ffv_d   = '0;
                    ffvld_d = 1'b0;
                    pass_d  = 1'b0;
                end
            end

            ST_SWEEP: begin
                bus.vec  = sweep_vec;
                bus.busy = 1'b1;
                hold_d   = hold_q + HW'(1);
                if (compare_edge) begin
                    hold_d = '0;
                    idx_d  = idx_q + N'(1);
                    if (miscompare) begin
                        cnt_d = cnt_q + (N+1)'(1);
                        // Only the earliest failing vector in sweep order is kept.
                        if (!ffvld_q) begin
                            ffv_d   = sweep_vec;
                            ffvld_d = 1'b1;
                        end
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                        idx_d   = '0;
                        // Uses the count including this final compare.
                        pass_d  = (cnt_d == '0);
                    end
                end
            end

            ST_DONE: begin
                bus.done = 1'b1;
                state_d  = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.pass             = pass_q;
    assign bus.mismatch_count   = cnt_q;
    assign bus.first_fail_vec   = ffv_q;
    assign bus.first_fail_valid = ffvld_q;

endmodule
